// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, requester IDs and default widths.
package sram_arbiter_pkg;

  localparam int DEF_ADDR_W     = 21;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_STARVE_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    H_SETUP,
    H_STROBE,
    H_RECOVER
  } arb_state_e;

  typedef logic req_id_t;
  localparam req_id_t ID_LDR = 1'b0;
  localparam req_id_t ID_RB  = 1'b1;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker; on a tie the previous winner loses, and the loader
// wins the first tie after reset. Purely combinational pick, winner registered on i_take.
module sram_arb_rr
  import sram_arbiter_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_ldr_req,
  input  logic    i_rb_req,
  input  logic    i_take,
  output logic    o_any,
  output req_id_t o_id
);

  req_id_t r_last;

  always_comb begin
    o_any = i_ldr_req | i_rb_req;
    o_id  = ID_LDR;
    if (i_ldr_req && i_rb_req) begin
      o_id = (r_last == ID_LDR) ? ID_RB : ID_LDR;
    end else if (i_rb_req) begin
      o_id = ID_RB;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last <= ID_RB;
    end else if (i_take && o_any) begin
      r_last <= o_id;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between the core DRAM strobes (always wins, same-cycle preemption)
// and host loader/readback ports (3-cycle slot, req/ack). SRAM_ARB_READBACK_EN enables readback.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
)(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic              i_core_ras_n,
  input  logic              i_core_cas_n,
  input  logic              i_core_we_n,
  input  logic [DATA_W-1:0] i_core_din,
  output logic [DATA_W-1:0] o_core_dout,
  input  logic              i_ldr_req,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [DATA_W-1:0] i_ldr_data,
  output logic              o_ldr_ack,
  input  logic              i_rb_req,
  input  logic [ADDR_W-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  output logic              o_rb_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_data,
  output logic              o_sram_we_n,
  output logic              o_host_starved
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e        r_state, w_state_nxt;
  req_id_t           r_win, w_pick;
  logic [ADDR_W-1:0] r_core_addr, r_host_addr, w_host_addr_sel;
  logic [DATA_W-1:0] r_host_data, r_core_dout, w_drv_dat;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_starved;
  logic              w_any, w_pend, w_grant, w_core_owns, w_core_we_n, w_core_rd;
  logic              w_sram_we_n, w_drv_en, w_ldr_ack, w_ack_any;

  assign w_core_we_n = i_core_ras_n | i_core_cas_n | i_core_we_n;
  assign w_core_rd   = ~i_core_ras_n & ~i_core_cas_n & i_core_we_n;
  // RAS low hands the bus back to the core in the same cycle, whatever the FSM is doing.
  assign w_core_owns = (r_state == IDLE) | ~i_core_ras_n;
  assign w_grant     = (r_state == IDLE) & i_core_ras_n & w_any & ~i_reset;

`ifdef SRAM_ARB_READBACK_EN
  logic              w_rb_ack;
  logic [DATA_W-1:0] r_rb_data;

  sram_arb_rr u_rr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_ldr_req (i_ldr_req),
    .i_rb_req  (i_rb_req),
    .i_take    (w_grant),
    .o_any     (w_any),
    .o_id      (w_pick)
  );

  assign w_pend          = i_ldr_req | i_rb_req;
  assign w_host_addr_sel = (w_pick == ID_RB) ? i_rb_addr : i_ldr_addr;
  assign w_rb_ack        = ~i_reset & ~w_core_owns & (r_state == H_RECOVER) & (r_win == ID_RB);
  assign w_ack_any       = w_ldr_ack | w_rb_ack;
  assign o_rb_ack        = w_rb_ack;
  assign o_rb_data       = r_rb_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rb_data <= '0;
    end else if (~w_core_owns && (r_state == H_STROBE) && (r_win == ID_RB)) begin
      r_rb_data <= io_sram_data;
    end
  end
`else
  logic w_unused_rb;

  assign w_unused_rb     = ^{i_rb_req, i_rb_addr};
  assign w_any           = i_ldr_req;
  assign w_pick          = ID_LDR;
  assign w_pend          = i_ldr_req;
  assign w_host_addr_sel = i_ldr_addr;
  assign w_ack_any       = w_ldr_ack;
  assign o_rb_ack        = 1'b0;
  assign o_rb_data       = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_grant) w_state_nxt = H_SETUP;
      H_SETUP:   w_state_nxt = H_STROBE;
      H_STROBE:  w_state_nxt = H_RECOVER;
      H_RECOVER: w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    if (!i_core_ras_n) w_state_nxt = IDLE;
  end

  always_comb begin
    o_sram_addr = r_core_addr;
    w_sram_we_n = w_core_we_n;
    w_drv_en    = ~w_core_we_n;
    w_drv_dat   = i_core_din;
    w_ldr_ack   = 1'b0;
    if (!w_core_owns) begin
      o_sram_addr = r_host_addr;
      w_drv_en    = (r_win == ID_LDR);
      w_drv_dat   = r_host_data;
      w_sram_we_n = ~((r_state == H_STROBE) && (r_win == ID_LDR));
      w_ldr_ack   = (r_state == H_RECOVER) && (r_win == ID_LDR);
    end
    if (i_reset) begin
      w_sram_we_n = 1'b1;
      w_drv_en    = 1'b0;
      w_ldr_ack   = 1'b0;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_ack_any) begin
      w_cnt_nxt = '0;
    end else if (w_pend && (r_cnt != STARVE_LIM)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_win       <= ID_LDR;
      r_core_addr <= '0;
      r_host_addr <= '0;
      r_host_data <= '0;
      r_core_dout <= '0;
      r_cnt       <= '0;
      r_starved   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!i_core_ras_n) r_core_addr <= i_core_addr;
      if (w_core_rd) r_core_dout <= io_sram_data;
      // A preempted request is re-latched on its next grant; rewriting is harmless.
      if (w_grant) begin
        r_win       <= w_pick;
        r_host_addr <= w_host_addr_sel;
        r_host_data <= i_ldr_data;
      end
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == STARVE_LIM) r_starved <= 1'b1;
    end
  end

  assign io_sram_data   = w_drv_en ? w_drv_dat : 'z;
  assign o_sram_we_n    = w_sram_we_n;
  assign o_ldr_ack      = w_ldr_ack;
  assign o_core_dout    = r_core_dout;
  assign o_host_starved = r_starved;

endmodule
